// File: rtl/vga_sched_pkg.sv
// Shared types and default constants for the VGA slot scheduler.
package vga_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHOW
  } sched_state_t;

  localparam int DEFAULT_NUM_SLOTS = 4;
  localparam int DEFAULT_DWELL_SEC = 30;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the level-type one-second timer output.
// rise_out is combinational from level_in and the registered previous level.
module tick_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level_in,
  output logic rise_out
);

  logic tick_q;

  // Remember last cycle's level so a held-high level yields a single rise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= level_in;
    end
  end

  assign rise_out = level_in & ~tick_q;

endmodule

// File: rtl/vga_slot_scheduler.sv
// Steps the display through NUM_SLOTS image slots. Each slot is loaded into the
// frame buffer over a req/ack handshake, then shown for DWELL_SEC seconds
// counted on rising edges of sec_tick, then the next slot (with wrap) is loaded.
//
// Handshake (load_req/load_ack): load_req is the valid; load_ack is the ready.
// A transfer happens on a rising clock edge where load_req=1 and load_ack=1.
// While load_req=1, load_slot is stable. load_req only drops after a transfer
// or when the request is abandoned (enable=0 or reset); load_ack seen while
// load_req=0 has no effect.
module vga_slot_scheduler
  import vga_sched_pkg::*;
#(
  parameter  int NUM_SLOTS = DEFAULT_NUM_SLOTS,
  parameter  int DWELL_SEC = DEFAULT_DWELL_SEC,
  localparam int SLOT_W    = $clog2(NUM_SLOTS),
  localparam int CNT_W     = $clog2(DWELL_SEC + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              sec_tick,
  input  logic              pause,
  input  logic              skip,
  input  logic              load_ack,
  output logic              load_req,
  output logic [SLOT_W-1:0] load_slot,
  output logic [SLOT_W-1:0] slot_sel,
  output logic [CNT_W-1:0]  sec_left,
  output logic              slot_done,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  sched_state_t      state, state_n;
  logic              load_req_n, busy_n, slot_done_n;
  logic [SLOT_W-1:0] load_slot_n, slot_sel_n, next_slot;
  logic [CNT_W-1:0]  sec_left_n;
  logic              tick_edge;
  logic              count_en;
  logic              expire;

  tick_edge_detect u_tick_edge (
    .clock    (clock),
    .reset    (reset),
    .level_in (sec_tick),
    .rise_out (tick_edge)
  );

  // Successor of the displayed slot, wrapping after the last one.
  always_comb begin
    next_slot = slot_sel + SLOT_W'(1);
    if (slot_sel == SLOT_W'(NUM_SLOTS - 1)) begin
      next_slot = '0;
    end
  end

  assign count_en  = tick_edge & ~pause;
  assign expire    = count_en && (sec_left == CNT_W'(1));
  assign state_dbg = state;

  // Next-state and next-output logic; everything holds unless a branch changes it.
  always_comb begin
    state_n     = state;
    load_req_n  = load_req;
    busy_n      = busy;
    load_slot_n = load_slot;
    slot_sel_n  = slot_sel;
    sec_left_n  = sec_left;
    slot_done_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_n     = S_LOAD;
          load_req_n  = 1'b1;
          busy_n      = 1'b1;
          load_slot_n = slot_sel;
        end
      end
      S_LOAD: begin
        // Abandoning the request wins over a simultaneous ack.
        if (!enable) begin
          state_n    = S_IDLE;
          load_req_n = 1'b0;
          busy_n     = 1'b0;
        end else if (load_ack && load_req) begin
          state_n    = S_SHOW;
          load_req_n = 1'b0;
          busy_n     = 1'b0;
          slot_sel_n = load_slot;
          sec_left_n = CNT_W'(DWELL_SEC);
        end
      end
      S_SHOW: begin
        if (!enable) begin
          state_n    = S_IDLE;
          sec_left_n = '0;
        end else if (expire || skip) begin
          // Expiry and skip together advance once; slot_done follows expiry only.
          state_n     = S_LOAD;
          load_req_n  = 1'b1;
          busy_n      = 1'b1;
          load_slot_n = next_slot;
          sec_left_n  = '0;
          slot_done_n = expire;
        end else if (count_en && (sec_left > CNT_W'(1))) begin
          sec_left_n = sec_left - CNT_W'(1);
        end
      end
      default: begin
        state_n    = S_IDLE;
        load_req_n = 1'b0;
        busy_n     = 1'b0;
        sec_left_n = '0;
      end
    endcase
  end

  // State and registered outputs; async reset clears everything, dropping load_req at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      load_req  <= 1'b0;
      busy      <= 1'b0;
      load_slot <= '0;
      slot_sel  <= '0;
      sec_left  <= '0;
      slot_done <= 1'b0;
    end else begin
      state     <= state_n;
      load_req  <= load_req_n;
      busy      <= busy_n;
      load_slot <= load_slot_n;
      slot_sel  <= slot_sel_n;
      sec_left  <= sec_left_n;
      slot_done <= slot_done_n;
    end
  end

endmodule

// File: tb/tb_vga_slot_scheduler.sv
// Self-checking bench for vga_slot_scheduler with NUM_SLOTS=4, DWELL_SEC=3.
// Each stimulus cycle pushes the output snapshot expected after the next clock
// edge; the snapshot is popped and compared one time unit after that edge.
module tb_vga_slot_scheduler;
  import vga_sched_pkg::*;

  localparam int NS = 4;
  localparam int DW = 3;

  logic       clock;
  logic       reset;
  logic       enable, sec_tick, pause, skip, load_ack;
  logic       load_req, slot_done, busy;
  logic [1:0] load_slot, slot_sel, sec_left, state_dbg;

  int errors = 0;
  int checks = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];
  logic [1:0]  sel;

  vga_slot_scheduler #(.NUM_SLOTS(NS), .DWELL_SEC(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .sec_tick  (sec_tick),
    .pause     (pause),
    .skip      (skip),
    .load_ack  (load_ack),
    .load_req  (load_req),
    .load_slot (load_slot),
    .slot_sel  (slot_sel),
    .sec_left  (sec_left),
    .slot_done (slot_done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [10:0] pk(sched_state_t st, logic lr, logic [1:0] ls,
                                     logic [1:0] ss, logic [1:0] sl, logic sd, logic bz);
    return {st, lr, ls, ss, sl, sd, bz};
  endfunction

  function automatic logic [10:0] snap();
    return {state_dbg, load_req, load_slot, slot_sel, sec_left, slot_done, busy};
  endfunction

  function automatic logic [1:0] nxt(logic [1:0] s);
    return (s == 2'(NS - 1)) ? 2'd0 : s + 2'd1;
  endfunction

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of inputs, record expectation, compare after the edge
  task automatic step(input string tag, input logic en, input logic tk, input logic pa,
                      input logic sk, input logic ack, input logic [10:0] exp);
    enable   = en;
    sec_tick = tk;
    pause    = pa;
    skip     = sk;
    load_ack = ack;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    check_val(tag_q.pop_front(), 16'(snap()), 16'(exp_q.pop_front()));
  endtask

  // Hold ack low for d cycles, then ack; ends in SHOW with a full dwell.
  task automatic do_load(input logic [1:0] s, input int d);
    for (int i = 0; i < d; i++) begin
      step("load_wait", 1, 0, 0, 0, 0, pk(S_LOAD, 1, s, sel, 2'd0, 0, 1));
    end
    step("load_ack", 1, 0, 0, 0, 1, pk(S_SHOW, 0, s, s, 2'(DW), 0, 0));
    sel = s;
  endtask

  // One sec_tick pulse in SHOW that decrements to 'after'.
  task automatic tick_dec(input logic [1:0] after);
    step("tick_dec", 1, 1, 0, 0, 0, pk(S_SHOW, 0, sel, sel, after, 0, 0));
    step("tick_low", 1, 0, 0, 0, 0, pk(S_SHOW, 0, sel, sel, after, 0, 0));
  endtask

  // Count the full dwell down and expire into the next slot's LOAD.
  task automatic countdown();
    for (int k = DW; k > 1; k--) begin
      tick_dec(2'(k - 1));
    end
    step("expire", 1, 1, 0, 0, 0, pk(S_LOAD, 1, nxt(sel), sel, 2'd0, 1, 1));
    step("done_clr", 1, 0, 0, 0, 0, pk(S_LOAD, 1, nxt(sel), sel, 2'd0, 0, 1));
  endtask

  initial begin
    reset = 1'b0; enable = 0; sec_tick = 0; pause = 0; skip = 0; load_ack = 0;
    sel = 2'd0;
    #12;
    check_val("reset_state", 16'(snap()), 16'(pk(S_IDLE, 0, 0, 0, 0, 0, 0)));
    reset = 1'b1;

    step("idle_hold", 0, 0, 0, 0, 0, pk(S_IDLE, 0, 0, 0, 0, 0, 0));
    step("en_req", 1, 0, 0, 0, 0, pk(S_LOAD, 1, 0, 0, 0, 0, 1));
    do_load(2'd0, 2);
    countdown();

    // Slots 1..3; the last expiry wraps load_slot to 0.
    for (int s = 1; s < NS; s++) begin
      do_load(2'(s), $urandom_range(0, 3));
      countdown();
    end
    do_load(2'd0, $urandom_range(0, 3));

    // Pause freezes the count across two tick edges.
    for (int i = 0; i < 2; i++) begin
      step("pause_tick", 1, 1, 1, 0, 0, pk(S_SHOW, 0, 0, 0, 2'(DW), 0, 0));
      step("pause_low", 1, 0, 1, 0, 0, pk(S_SHOW, 0, 0, 0, 2'(DW), 0, 0));
    end
    step("skip_pause", 1, 0, 1, 1, 0, pk(S_LOAD, 1, 1, 0, 0, 0, 1));
    do_load(2'd1, $urandom_range(0, 3));

    // Held-high sec_tick decrements once.
    step("held_first", 1, 1, 0, 0, 0, pk(S_SHOW, 0, 1, 1, 2, 0, 0));
    for (int i = 0; i < 5; i++) begin
      step("held_hold", 1, 1, 0, 0, 0, pk(S_SHOW, 0, 1, 1, 2, 0, 0));
    end
    step("held_low", 1, 0, 0, 0, 0, pk(S_SHOW, 0, 1, 1, 2, 0, 0));
    tick_dec(2'd1);

    // Skip coinciding with expiry: single advance, slot_done still pulses.
    step("skip_expire", 1, 1, 0, 1, 0, pk(S_LOAD, 1, 2, 1, 0, 1, 1));
    step("skip_exp_clr", 1, 0, 0, 0, 0, pk(S_LOAD, 1, 2, 1, 0, 0, 1));

    // Abandon a request, then re-enable: held slot_sel is requested again.
    step("abandon", 0, 0, 0, 0, 0, pk(S_IDLE, 0, 2, 1, 0, 0, 0));
    step("idle_again", 0, 0, 0, 0, 0, pk(S_IDLE, 0, 2, 1, 0, 0, 0));
    step("reenable", 1, 0, 0, 0, 0, pk(S_LOAD, 1, 1, 1, 0, 0, 1));
    step("dis_over_ack", 0, 0, 0, 0, 1, pk(S_IDLE, 0, 1, 1, 0, 0, 0));
    step("reenable2", 1, 0, 0, 0, 0, pk(S_LOAD, 1, 1, 1, 0, 0, 1));
    step("load_ignores", 1, 1, 1, 1, 0, pk(S_LOAD, 1, 1, 1, 0, 0, 1));
    step("load_tick_low", 1, 0, 0, 0, 0, pk(S_LOAD, 1, 1, 1, 0, 0, 1));
    do_load(2'd1, 0);
    tick_dec(2'd2);

    // Disable in SHOW clears sec_left and keeps slot_sel; re-enable reloads it.
    step("show_disable", 0, 0, 0, 0, 0, pk(S_IDLE, 0, 1, 1, 0, 0, 0));
    step("reenable3", 1, 0, 0, 0, 0, pk(S_LOAD, 1, 1, 1, 0, 0, 1));
    do_load(2'd1, 1);
    tick_dec(2'd2);

    // Async reset mid-SHOW, between clock edges.
    #2;
    reset = 1'b0;
    #1;
    check_val("async_rst_show", 16'(snap()), 16'(pk(S_IDLE, 0, 0, 0, 0, 0, 0)));
    @(posedge clock);
    #1;
    reset = 1'b1;
    sel = 2'd0;
    step("post_rst_req", 1, 0, 0, 0, 0, pk(S_LOAD, 1, 0, 0, 0, 0, 1));

    // Async reset mid-LOAD drops load_req at once.
    #2;
    reset = 1'b0;
    #1;
    check_val("async_rst_load", 16'({load_req, busy}), 16'(0));
    check_val("async_rst_all", 16'(snap()), 16'(pk(S_IDLE, 0, 0, 0, 0, 0, 0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
